// File: rtl/td4_run_ctrl.sv
// rtl/td4_run_ctrl.sv - run/load controller for the 4-bit TD4-style CPU
module td4_run_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int CYC_W  = 16
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [ADDR_W-1:0] cpu_address,
    output logic [DATA_W-1:0] cpu_instr,
    output logic              cpu_n_reset,
    output logic              cpu_clk_en,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    output logic [1:0]        state,
    output logic              hit_bp,
    output logic [CYC_W-1:0]  cyc_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10,
        S_HALT = 2'b11
    } state_t;

    state_t              st;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic                bp_skip;
    logic                hit_bp_r;
    logic [CYC_W-1:0]    cyc_r;

    logic                cmd_fire;
    logic                bp_stop;
    logic                cyc_inc;

    assign cmd_ready = (st != S_STEP);
    assign cmd_fire  = cmd_valid && cmd_ready;
    // bp_skip lets the instruction we resumed on execute even if it is the breakpoint
    assign bp_stop   = bp_en && (cpu_address == bp_addr) && !bp_skip;
    assign cpu_instr = mem[cpu_address];
    assign state     = st;
    assign hit_bp    = hit_bp_r;
    assign cyc_count = cyc_r;
    assign cyc_inc   = cpu_n_reset && cpu_clk_en;

    // CPU reset / clock-enable decode from the current state
    always_comb begin
        cpu_n_reset = 1'b1;
        cpu_clk_en  = 1'b0;
        case (st)
            S_IDLE: begin
                cpu_n_reset = 1'b0;
                cpu_clk_en  = 1'b1;
            end
            S_RUN:  cpu_clk_en = !bp_stop;
            S_STEP: cpu_clk_en = 1'b1;
            S_HALT: cpu_clk_en = 1'b0;
            default: begin
                cpu_n_reset = 1'b0;
                cpu_clk_en  = 1'b0;
            end
        endcase
    end

    // Controller state, program memory, breakpoint flags and instruction counter
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            st       <= S_IDLE;
            wr_ptr   <= '0;
            bp_skip  <= 1'b0;
            hit_bp_r <= 1'b0;
            cyc_r    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // counts every enabled CPU edge, saturating rather than wrapping
            if (cyc_inc && (cyc_r != {CYC_W{1'b1}})) begin
                cyc_r <= cyc_r + CYC_W'(1);
            end

            case (st)
                S_IDLE: begin
                    if (cmd_fire) begin
                        case (cmd_op)
                            OP_LOAD: begin
                                mem[wr_ptr] <= cmd_data;
                                wr_ptr      <= wr_ptr + ADDR_W'(1);
                            end
                            OP_RUN: begin
                                st       <= S_RUN;
                                bp_skip  <= 1'b1;
                                hit_bp_r <= 1'b0;
                            end
                            OP_STEP: begin
                                st       <= S_STEP;
                                hit_bp_r <= 1'b0;
                            end
                            default: wr_ptr <= '0;
                        endcase
                    end
                end
                S_RUN: begin
                    bp_skip <= 1'b0;
                    // a breakpoint wins over a simultaneous HALT so hit_bp is still reported
                    if (bp_stop) begin
                        st       <= S_HALT;
                        hit_bp_r <= 1'b1;
                    end else if (cmd_fire && (cmd_op == OP_HALT)) begin
                        st <= S_HALT;
                    end
                end
                S_STEP: begin
                    st <= S_HALT;
                end
                S_HALT: begin
                    if (cmd_fire) begin
                        case (cmd_op)
                            OP_RUN: begin
                                st       <= S_RUN;
                                bp_skip  <= 1'b1;
                                hit_bp_r <= 1'b0;
                            end
                            OP_STEP: begin
                                st       <= S_STEP;
                                hit_bp_r <= 1'b0;
                            end
                            OP_HALT: begin
                                st       <= S_IDLE;
                                wr_ptr   <= '0;
                                cyc_r    <= '0;
                                hit_bp_r <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_td4_run_ctrl.sv
// tb/tb_td4_run_ctrl.sv - directed self-checking bench for td4_run_ctrl
module tb_td4_run_ctrl;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_data;
    logic [3:0]  cpu_address;
    logic [7:0]  cpu_instr;
    logic        cpu_n_reset;
    logic        cpu_clk_en;
    logic        bp_en;
    logic [3:0]  bp_addr;
    logic [1:0]  state;
    logic        hit_bp;
    logic [15:0] cyc_count;

    logic [3:0]  pc;
    logic        use_ovr;
    logic [3:0]  ovr_addr;

    int passed = 0;
    int fails  = 0;
    int total  = 0;
    int n;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    always #5 clk = ~clk;

    td4_run_ctrl dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_data    (cmd_data),
        .cpu_address (cpu_address),
        .cpu_instr   (cpu_instr),
        .cpu_n_reset (cpu_n_reset),
        .cpu_clk_en  (cpu_clk_en),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .state       (state),
        .hit_bp      (hit_bp),
        .cyc_count   (cyc_count)
    );

    // Minimal CPU model: PC clears in reset and advances on each enabled edge
    always @(posedge clk or negedge n_reset) begin
        if (!n_reset)          pc <= 4'd0;
        else if (!cpu_n_reset) pc <= 4'd0;
        else if (cpu_clk_en)   pc <= pc + 4'd1;
    end

    assign cpu_address = use_ovr ? ovr_addr : pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        n_reset   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 8'h00;
        bp_en     = 1'b0;
        bp_addr   = 4'd0;
        use_ovr   = 1'b0;
        ovr_addr  = 4'd0;
        #12;
        check("rst_state", state, 2'b00);
        check("rst_ready", cmd_ready, 1);
        check("rst_cpu_n_reset", cpu_n_reset, 0);
        check("rst_clk_en", cpu_clk_en, 1);
        check("rst_cyc", cyc_count, 0);
        check("rst_hit_bp", hit_bp, 0);
        check("rst_instr", cpu_instr, 8'h00);
        n_reset = 1'b1;
        tick();

        // load a short program and run it
        send(OP_LOAD, 8'h31);
        check("load_visible", cpu_instr, 8'h31);
        send(OP_LOAD, 8'hB3);
        send(OP_LOAD, 8'hF0);
        send(OP_RUN, 8'h00);
        check("run_state", state, 2'b01);
        check("run_cpu_n_reset", cpu_n_reset, 1);
        check("run_cyc0", cyc_count, 0);
        check("run_instr0", cpu_instr, 8'h31);
        tick();
        check("run_cyc1", cyc_count, 1);
        check("run_instr1", cpu_instr, 8'hB3);
        tick();
        check("run_cyc2", cyc_count, 2);
        check("run_instr2", cpu_instr, 8'hF0);
        send(OP_HALT, 8'h00);
        check("halt_state", state, 2'b11);
        check("halt_cyc", cyc_count, 3);
        check("halt_clk_en", cpu_clk_en, 0);
        send(OP_HALT, 8'h00);
        check("idle_state", state, 2'b00);
        check("idle_cyc", cyc_count, 0);

        // 17 loads: write pointer wraps and overwrites word 0
        for (int i = 0; i < 17; i++) begin
            check("load_ready", cmd_ready, 1);
            send(OP_LOAD, 8'(i));
        end
        use_ovr  = 1'b1;
        ovr_addr = 4'd0;
        #1;
        check("wrap_mem0", cpu_instr, 8'h10);
        ovr_addr = 4'd1;
        #1;
        check("wrap_mem1", cpu_instr, 8'h01);
        use_ovr  = 1'b0;

        // three single steps
        for (int i = 1; i <= 3; i++) begin
            send(OP_STEP, 8'h00);
            check("step_state", state, 2'b10);
            check("step_ready", cmd_ready, 0);
            check("step_clk_en", cpu_clk_en, 1);
            tick();
            check("step_back_halt", state, 2'b11);
            check("step_cyc", cyc_count, 32'(i));
        end
        check("step_pc", pc, 3);
        send(OP_HALT, 8'h00);
        check("step_idle", state, 2'b00);

        // breakpoint at address 3
        bp_en   = 1'b1;
        bp_addr = 4'd3;
        send(OP_RUN, 8'h00);
        tick();
        tick();
        tick();
        check("bp_addr_reached", cpu_address, 3);
        check("bp_clk_en_low", cpu_clk_en, 0);
        check("bp_still_run", state, 2'b01);
        tick();
        check("bp_halt", state, 2'b11);
        check("bp_hit", hit_bp, 1);
        check("bp_cyc", cyc_count, 3);
        send(OP_RUN, 8'h00);
        check("bp_resume_hit_clr", hit_bp, 0);
        check("bp_resume_clk_en", cpu_clk_en, 1);
        n = 0;
        for (int i = 0; i < 40 && state != 2'b11; i++) begin
            tick();
            n++;
        end
        check("bp_second_ticks", n, 17);
        check("bp_second_state", state, 2'b11);
        check("bp_second_pc", cpu_address, 3);
        check("bp_second_cyc", cyc_count, 19);
        check("bp_second_hit", hit_bp, 1);
        send(OP_HALT, 8'h00);
        check("bp_idle_hit", hit_bp, 0);
        bp_en = 1'b0;

        // commands ignored during RUN, then async reset
        send(OP_RUN, 8'h00);
        send(OP_LOAD, 8'hAA);
        send(OP_STEP, 8'h00);
        check("ign_state", state, 2'b01);
        check("ign_instr", cpu_instr, 8'h02);
        use_ovr  = 1'b1;
        ovr_addr = 4'd0;
        #1;
        check("ign_mem0", cpu_instr, 8'h10);
        n_reset = 1'b0;
        #1;
        check("arst_state", state, 2'b00);
        check("arst_cyc", cyc_count, 0);
        check("arst_cpu_n_reset", cpu_n_reset, 0);
        for (int a = 0; a < 16; a++) begin
            ovr_addr = 4'(a);
            #1;
            check("arst_mem", cpu_instr, 8'h00);
        end
        use_ovr = 1'b0;
        n_reset = 1'b1;
        tick();

        // counter saturation
        send(OP_RUN, 8'h00);
        repeat (65534) @(posedge clk);
        #1;
        check("sat_fffe", cyc_count, 16'hFFFE);
        tick();
        tick();
        tick();
        check("sat_ffff", cyc_count, 16'hFFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
